// File: rtl/pipe_stage_hs_pkg.sv
// Shared hold-bus encoding, NOP word and stage-state constants for pipe_stage_hs.
// Hold levels are ordered: a larger code stalls more of the pipeline.
// The squash helper is the single definition of when a stage is flushed.
package pipe_stage_hs_pkg;

    localparam int HOLD_FLAG_W = 3;
    typedef logic [HOLD_FLAG_W-1:0] hold_flag_t;

    localparam hold_flag_t HOLD_NONE = 3'b000;
    localparam hold_flag_t HOLD_PC   = 3'b001;
    localparam hold_flag_t HOLD_IF   = 3'b010;
    localparam hold_flag_t HOLD_ID   = 3'b011;
    localparam hold_flag_t HOLD_EX   = 3'b100;

    localparam logic [31:0] INST_NOP = 32'h0000_0001;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    function automatic logic stage_squash(input logic flush,
                                          input hold_flag_t hold,
                                          input hold_flag_t level);
        return flush | (hold >= level);
    endfunction

endpackage

// File: rtl/pipe_stage_hs_entry.sv
// One pipeline storage entry: valid bit plus payload, clear beats load.
// Latency: 1 cycle from load to dat. Backpressure: none, the parent decides load/clear.
// Cleared and reset contents read as NOP_VALUE so an empty entry never leaks stale data.
module pipe_entry_dff #(
    parameter int             DW        = 32,
    parameter logic [DW-1:0]  NOP_VALUE = {DW{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          clear,
    input  logic [DW-1:0] d,
    output logic          vld,
    output logic [DW-1:0] dat
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= 1'b0;
            dat <= NOP_VALUE;
        end else if (clear) begin
            vld <= 1'b0;
            dat <= NOP_VALUE;
        end else if (load) begin
            vld <= 1'b1;
            dat <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline register with hold-level and flush squash; 1-cycle latency.
// Backpressure: single entry by default; PIPE_STAGE_HS_SKID_EN adds a skid entry and a
// registered in_ready_o with no combinational path from out_ready_i.
module pipe_stage_hs
    import pipe_stage_hs_pkg::*;
#(
    parameter int             DW         = 32,
    parameter hold_flag_t     HOLD_LEVEL = HOLD_EX,
    parameter logic [DW-1:0]  NOP_VALUE  = {DW{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    input  hold_flag_t    hold_flag_i,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic [1:0]    count_o
);

    logic          squash;
    logic          xfer_in;
    logic          xfer_out;
    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic          ready_q;
    logic          head_load;
    logic          head_clear;
    logic [DW-1:0] head_d;
    logic          head_vld;
    logic [DW-1:0] head_dat;

    assign squash      = stage_squash(flush_i, hold_flag_i, HOLD_LEVEL);
    assign xfer_in     = in_valid_i & in_ready_o;
    assign xfer_out    = head_vld & out_ready_i;
    assign out_valid_o = head_vld;
    assign out_data_o  = head_dat;
    assign count_o     = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_entry_dff #(.DW(DW), .NOP_VALUE(NOP_VALUE)) u_head (
        .clk   (clk),
        .rst   (rst),
        .load  (head_load),
        .clear (head_clear),
        .d     (head_d),
        .vld   (head_vld),
        .dat   (head_dat)
    );

`ifdef PIPE_STAGE_HS_SKID_EN
    logic          skid_load;
    logic          skid_clear;
    logic          skid_vld;
    logic [DW-1:0] skid_dat;

    // Room is computed from the next state so in_ready_o is a flop, gated only by squash.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= (state_d != ST_TWO);
        end
    end

    assign in_ready_o = ready_q & ~squash;

    always_comb begin
        head_load  = 1'b0;
        head_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        head_d     = in_data_i;
        state_d    = state_q;
        if (squash) begin
            head_clear = 1'b1;
            skid_clear = 1'b1;
            state_d    = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (xfer_in) begin
                        head_load = 1'b1;
                        state_d   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (xfer_in && xfer_out) begin
                        head_load = 1'b1;
                    end else if (xfer_in) begin
                        skid_load = 1'b1;
                        state_d   = ST_TWO;
                    end else if (xfer_out) begin
                        head_clear = 1'b1;
                        state_d    = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // Older entry leaves; the skid entry moves up to the output.
                    if (xfer_out && skid_vld) begin
                        head_d     = skid_dat;
                        head_load  = 1'b1;
                        skid_clear = 1'b1;
                        state_d    = ST_ONE;
                    end
                end
                default: begin
                    head_clear = 1'b1;
                    skid_clear = 1'b1;
                    state_d    = ST_EMPTY;
                end
            endcase
        end
    end

    pipe_entry_dff #(.DW(DW), .NOP_VALUE(NOP_VALUE)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_data_i),
        .vld   (skid_vld),
        .dat   (skid_dat)
    );
`else
    // ready_q only marks "out of reset" so in_ready_o stays low through reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign in_ready_o = ready_q & (~head_vld | out_ready_i) & ~squash;

    always_comb begin
        head_load  = 1'b0;
        head_clear = 1'b0;
        head_d     = in_data_i;
        state_d    = state_q;
        if (squash) begin
            head_clear = 1'b1;
            state_d    = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (xfer_in) begin
                        head_load = 1'b1;
                        state_d   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (xfer_in) begin
                        head_load = 1'b1;
                    end else if (xfer_out) begin
                        head_clear = 1'b1;
                        state_d    = ST_EMPTY;
                    end
                end
                default: begin
                    head_clear = 1'b1;
                    state_d    = ST_EMPTY;
                end
            endcase
        end
    end
`endif

endmodule

// File: doc/pipe_stage_hs.md
PIPE_STAGE_HS -- requirements
Module: pipe_stage_hs

Interface
REQ-001 SHALL have parameter DW, default 32, payload width in bits (1..256).
REQ-002 SHALL have parameter HOLD_LEVEL, default `Hold_Ex`, the hold_flag_i threshold at which this stage is squashed.
REQ-003 SHALL have parameter NOP_VALUE, default {DW{1'b0}}, bubble payload.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port hold_flag_i  input  `Hold_Flag_Bus`  pipeline hold code.
REQ-007 SHALL have port flush_i  input  1  explicit squash request.
REQ-008 SHALL have port in_valid_i  input  1  upstream payload valid.
REQ-009 SHALL have port in_ready_o  output  1  stage can accept.
REQ-010 SHALL have port in_data_i  input  DW  upstream payload.
REQ-011 SHALL have port out_valid_o  output  1  payload valid downstream.
REQ-012 SHALL have port out_ready_i  input  1  downstream accepts.
REQ-013 SHALL have port out_data_o  output  DW  registered payload.
REQ-014 SHALL have port count_o  output  2  entries held (0..2).

Function
REQ-015 SHALL define squash = flush_i | (hold_flag_i >= HOLD_LEVEL), unsigned compare.
REQ-016 SHALL define a transfer in = in_valid_i & in_ready_o and a transfer out = out_valid_o & out_ready_i, both sampled at the rising edge.
REQ-017 SHALL deliver accepted payloads in order, with latency 1 cycle (payload accepted at edge N is visible at out_data_o after edge N when the stage was empty).
REQ-018 SHALL drive out_data_o = NOP_VALUE whenever out_valid_o = 0.
REQ-019 SHALL hold out_data_o and out_valid_o stable while out_valid_o = 1 and out_ready_i = 0.
REQ-020 SHALL, on a squashing edge, set count to 0 and out_valid_o to 0, and discard any same-edge transfer in; squash wins over every simultaneous event.
REQ-021 SHALL force in_ready_o = 0 while squash is high.
REQ-022 SHALL, in states EMPTY/ONE/TWO (count 0/1/2), move EMPTY->ONE on in; ONE->TWO on in without out; TWO->ONE on out; ONE->EMPTY on out without in; ONE stays ONE on simultaneous in and out.
REQ-023 SHALL, in TWO, present the older entry at the output and promote the skid entry on a transfer out.
REQ-024 SHALL keep count_o equal to the current state encoding.

Reset
REQ-025 SHALL, while rst = 1, asynchronously force count_o = 0, out_valid_o = 0, out_data_o = NOP_VALUE and in_ready_o = 0.
REQ-026 SHALL drive in_ready_o = 1 at the first edge after rst deasserts, with no squash active.
REQ-027 SHALL lose all in-flight payloads when reset asserts mid-operation; no partial entry survives.

Configuration
REQ-028 SHALL support the macro PIPE_STAGE_HS_SKID_EN.
REQ-029 SHALL, with PIPE_STAGE_HS_SKID_EN defined, use two entries and drive in_ready_o = (count < 2) & ~squash, registered apart from squash and with no combinational path from out_ready_i.
REQ-030 SHALL, without PIPE_STAGE_HS_SKID_EN, use one entry with count_o never above 1 and in_ready_o = (~out_valid_o | out_ready_i) & ~squash.

Structure
REQ-031 SHALL take Hold_Flag_Bus, the Hold_* levels and INST_NOP from the shared defines.v; no new global constants are required.
REQ-032 SHALL place one storage entry (valid bit plus DW payload, with load, clear and async reset) in sub-module pipe_entry_dff, instantiated once or twice.
REQ-033 SHALL, when used as the ex_mem successor, carry the concatenated EX->MEM fields as one DW-wide payload.

Verification
REQ-034 SHALL cover a stream: DW=32, out_ready_i = 1, inputs 0x11, 0x22, 0x33 on consecutive cycles -> same values out, 1-cycle latency, count_o = 1.
REQ-035 SHALL cover backpressure with the skid enabled: out_ready_i = 0 and inputs 0xA, 0xB -> count_o = 2, in_ready_o = 0; releasing out_ready_i -> 0xA then 0xB out.
REQ-036 SHALL cover hold: hold_flag_i = `Hold_Ex` with 2 entries and in_valid_i = 1 -> next cycle out_valid_o = 0, out_data_o = NOP_VALUE, count_o = 0, input not taken.
REQ-037 SHALL cover a lower hold: hold_flag_i = `Hold_Pc` (below HOLD_LEVEL) -> normal flow and no squash.
REQ-038 SHALL cover reset mid-operation: rst pulsed between edges while count_o = 2 -> outputs immediately at reset values and no stale 0xB afterwards.
REQ-039 SHALL cover the build without the skid: out_ready_i = 0 and input 0x5 -> in_ready_o = 0 after one accept; out_ready_i = 1 with in_valid_i = 1 -> in_ready_o = 1 in the same cycle.
